// File: rtl/psum_buf_pkg.sv
// Shared types and arithmetic helpers for the partial-sum accumulation buffer.
package psum_buf_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StFlush = 2'd2,
        StDrain = 2'd3
    } state_e;

    // Operands arrive sign-extended to 32 bits; bw selects the clamp range.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int unsigned bw,
                                                   output logic sat);
        logic signed [32:0] sum;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        sum = {a[31], a} + {b[31], b};
        hi  = (33'sd1 <<< (bw - 1)) - 33'sd1;
        lo  = -hi - 33'sd1;
        sat = 1'b0;
        if (sum > hi) begin
            sat     = 1'b1;
            sat_add = 32'(hi);
        end else if (sum < lo) begin
            sat     = 1'b1;
            sat_add = 32'(lo);
        end else begin
            sat_add = 32'(sum);
        end
    endfunction

    function automatic logic signed [31:0] relu(input logic signed [31:0] v);
        relu = (v < 0) ? 32'sd0 : v;
    endfunction

endpackage

// File: rtl/psum_bank.sv
// One channel bank: 1R1W, synchronous read, read-during-write returns old data.
module psum_bank #(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned PSUM_BW = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [PSUM_BW-1:0]       wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [PSUM_BW-1:0]       rdata
);

    logic [PSUM_BW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Q only moves on a read, so it holds while the consumer stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/psum_accum_buffer.sv
// Accumulates num_pass passes of COL-channel psum vectors into banks, then drains
// the tile with optional ReLU.
module psum_accum_buffer
    import psum_buf_pkg::*;
#(
    parameter int unsigned COL     = 8,
    parameter int unsigned PSUM_BW = 16,
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned PASS_W  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [$clog2(DEPTH):0]     num_pix,
    input  logic [PASS_W-1:0]          num_pass,
    input  logic                       relu_en,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [COL*PSUM_BW-1:0]     in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [COL*PSUM_BW-1:0]     out_data,
    output logic                       busy,
    output logic                       done,
    output logic                       sat_flag
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned W  = COL * PSUM_BW;

    state_e              state_q;
    logic [PW-1:0]       num_pix_q;
    logic [PASS_W-1:0]   num_pass_q;
    logic                relu_q;
    logic [AW-1:0]       pix_q;
    logic [PASS_W-1:0]   pass_q;
    logic [PW-1:0]       rd_ptr_q;
    logic                out_valid_q;
    logic                sat_q;

    // Write stage: holds the accepted vector while its bank read completes.
    logic                wr_valid_q;
    logic                wr_rmw_q;
    logic [AW-1:0]       wr_addr_q;
    logic [W-1:0]        wr_in_q;
    logic                fwd_q;
    logic [W-1:0]        fwd_data_q;

    logic [W-1:0]        wr_data;
    logic [W-1:0]        bank_q;
    logic [COL-1:0]      ch_sat;
    logic                accept;
    logic                issue;
    logic                last_pix;
    logic                last_pass;
    logic                cfg_ok;
    logic                bank_re;
    logic [AW-1:0]       bank_raddr;

    assign accept     = (state_q == StAccum) && in_valid;
    assign issue      = (state_q == StDrain) && (rd_ptr_q < num_pix_q) &&
                        (!out_valid_q || out_ready);
    assign last_pix   = (PW'(pix_q) == (num_pix_q - PW'(1)));
    assign last_pass  = (pass_q == (num_pass_q - PASS_W'(1)));
    assign cfg_ok     = (num_pix != '0) && (num_pix <= PW'(DEPTH)) && (num_pass != '0);
    assign bank_re    = accept || issue;
    assign bank_raddr = (state_q == StDrain) ? rd_ptr_q[AW-1:0] : pix_q;

    assign in_ready   = (state_q == StAccum);
    assign busy       = (state_q != StIdle);
    assign out_valid  = out_valid_q;
    assign sat_flag   = sat_q;
    assign done       = (state_q == StDrain) && out_valid_q && out_ready &&
                        (rd_ptr_q == num_pix_q);

    for (genvar c = 0; c < COL; c++) begin : g_ch
        logic signed [PSUM_BW-1:0] old_v;
        logic signed [PSUM_BW-1:0] in_v;
        logic signed [PSUM_BW-1:0] q_v;
        logic signed [PSUM_BW-1:0] sum_v;
        logic signed [PSUM_BW-1:0] relu_v;
        logic                      sat_v;

        // With num_pix=1 the bank Q is one write stale; take the in-flight value.
        assign old_v = fwd_q ? fwd_data_q[c*PSUM_BW +: PSUM_BW] : bank_q[c*PSUM_BW +: PSUM_BW];
        assign in_v  = wr_in_q[c*PSUM_BW +: PSUM_BW];
        assign q_v   = bank_q[c*PSUM_BW +: PSUM_BW];

        always_comb begin
            sat_v = 1'b0;
            sum_v = PSUM_BW'(sat_add({{(32-PSUM_BW){old_v[PSUM_BW-1]}}, old_v},
                                     {{(32-PSUM_BW){in_v[PSUM_BW-1]}}, in_v},
                                     PSUM_BW, sat_v));
        end

        always_comb begin
            relu_v = PSUM_BW'(relu({{(32-PSUM_BW){q_v[PSUM_BW-1]}}, q_v}));
        end

        assign wr_data[c*PSUM_BW +: PSUM_BW]  = wr_rmw_q ? sum_v : in_v;
        assign ch_sat[c]                      = wr_rmw_q && sat_v;
        assign out_data[c*PSUM_BW +: PSUM_BW] = !out_valid_q ? '0 : (relu_q ? relu_v : q_v);

        psum_bank #(
            .DEPTH   (DEPTH),
            .PSUM_BW (PSUM_BW)
        ) u_bank (
            .clk   (clk),
            .reset (reset),
            .we    (wr_valid_q),
            .waddr (wr_addr_q),
            .wdata (wr_data[c*PSUM_BW +: PSUM_BW]),
            .re    (bank_re),
            .raddr (bank_raddr),
            .rdata (bank_q[c*PSUM_BW +: PSUM_BW])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            num_pix_q   <= '0;
            num_pass_q  <= '0;
            relu_q      <= 1'b0;
            pix_q       <= '0;
            pass_q      <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_rmw_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_in_q     <= '0;
            fwd_q       <= 1'b0;
            fwd_data_q  <= '0;
        end else begin
            wr_valid_q <= accept;
            fwd_q      <= accept && wr_valid_q && (wr_addr_q == pix_q);
            if (accept) begin
                wr_addr_q <= pix_q;
                wr_rmw_q  <= (pass_q != '0);
                wr_in_q   <= in_data;
            end
            if (wr_valid_q) begin
                fwd_data_q <= wr_data;
                if (|ch_sat) begin
                    sat_q <= 1'b1;
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (start && cfg_ok) begin
                        num_pix_q  <= num_pix;
                        num_pass_q <= num_pass;
                        relu_q     <= relu_en;
                        pix_q      <= '0;
                        pass_q     <= '0;
                        rd_ptr_q   <= '0;
                        sat_q      <= 1'b0;
                        state_q    <= StAccum;
                    end
                end
                StAccum: begin
                    if (accept) begin
                        if (last_pix) begin
                            pix_q  <= '0;
                            pass_q <= pass_q + PASS_W'(1);
                            if (last_pass) begin
                                state_q <= StFlush;
                            end
                        end else begin
                            pix_q <= pix_q + AW'(1);
                        end
                    end
                end
                StFlush: begin
                    state_q <= StDrain;
                end
                StDrain: begin
                    if (issue) begin
                        rd_ptr_q    <= rd_ptr_q + PW'(1);
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                    if (done) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_accum_buffer.sv
// Randomised bench for psum_accum_buffer against a tile-level accumulation model.
module tb_psum_accum_buffer;

    localparam int COL     = 8;
    localparam int PSUM_BW = 16;
    localparam int DEPTH   = 64;
    localparam int PASS_W  = 4;
    localparam int PW      = $clog2(DEPTH) + 1;
    localparam int W       = COL * PSUM_BW;
    localparam int MAXV    = 32767;
    localparam int MINV    = -32768;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [PW-1:0]     num_pix;
    logic [PASS_W-1:0] num_pass;
    logic              relu_en;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_data;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_data;
    logic              busy;
    logic              done;
    logic              sat_flag;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] in_vecs[$];
    logic [W-1:0] out_q[$];
    logic [W-1:0] exp_q[$];
    bit exp_sat;
    int done_at, done_cnt, stall_err, first_lat;
    bit busy_start, busy_after, timed_out;

    psum_accum_buffer #(
        .COL     (COL),
        .PSUM_BW (PSUM_BW),
        .DEPTH   (DEPTH),
        .PASS_W  (PASS_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_pix   (num_pix),
        .num_pass  (num_pass),
        .relu_en   (relu_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] put_ch(input logic [W-1:0] vec, input int c, input int v);
        logic [W-1:0] r;
        r = vec;
        r[c*PSUM_BW +: PSUM_BW] = v[PSUM_BW-1:0];
        return r;
    endfunction

    function automatic int get_ch(input logic [W-1:0] vec, input int c);
        logic signed [PSUM_BW-1:0] t;
        t = vec[c*PSUM_BW +: PSUM_BW];
        return int'(t);
    endfunction

    function automatic logic [W-1:0] rand_vec(input int mag);
        logic [W-1:0] r;
        r = '0;
        for (int c = 0; c < COL; c++) begin
            r = put_ch(r, c, int'($urandom_range(2 * mag)) - mag);
        end
        return r;
    endfunction

    // Tile model: pass 0 loads, later passes add with clamping, drain applies ReLU.
    task automatic build_model(input int npix, input int npass, input bit relu);
        int acc[DEPTH][COL];
        int s;
        logic [W-1:0] v;
        exp_q.delete();
        exp_sat = 1'b0;
        for (int p = 0; p < npass; p++) begin
            for (int i = 0; i < npix; i++) begin
                for (int c = 0; c < COL; c++) begin
                    s = get_ch(in_vecs[p*npix+i], c);
                    if (p > 0) begin
                        s = acc[i][c] + s;
                        if (s > MAXV) begin s = MAXV; exp_sat = 1'b1; end
                        if (s < MINV) begin s = MINV; exp_sat = 1'b1; end
                    end
                    acc[i][c] = s;
                end
            end
        end
        for (int i = 0; i < npix; i++) begin
            v = '0;
            for (int c = 0; c < COL; c++) begin
                v = put_ch(v, c, (relu && acc[i][c] < 0) ? 0 : acc[i][c]);
            end
            exp_q.push_back(v);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Drives one full run from in_vecs and captures the drained vectors.
    task automatic do_job(input int npix, input int npass, input bit relu, input int rmode,
                          input bit gaps, input bit inject);
        int idx, cyc, total;
        bit held;
        logic [W-1:0] held_data;
        total = npix * npass;
        out_q.delete();
        done_at = -1; done_cnt = 0; stall_err = 0; first_lat = -1; timed_out = 1'b1;
        @(negedge clk);
        num_pix = PW'(npix); num_pass = PASS_W'(npass); relu_en = relu; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_start = busy;
        idx = 0; cyc = 0;
        while (idx < total && cyc < 4000) begin
            if (gaps && $urandom_range(3) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = in_vecs[idx];
            end
            start = inject && (cyc == 3);
            if (inject && cyc == 3) num_pix = PW'(1);
            if (in_valid && in_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        if (idx < total) begin
            checks++; errors++;
            $display("FAIL feed_timeout: accepted %0d required %0d", idx, total);
            pulse_reset();
            return;
        end
        held = 1'b0; held_data = '0;
        for (int cnt = 1; cnt <= 3000; cnt++) begin
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = (cnt % 4 == 1) || (cnt % 4 == 0);
                default: out_ready = 1'($urandom_range(1));
            endcase
            #1;
            if (out_valid && first_lat < 0) first_lat = cnt;
            if (held && (!out_valid || out_data !== held_data)) stall_err++;
            if (done && !(out_valid && out_ready)) stall_err++;
            if (out_valid && out_ready) begin
                out_q.push_back(out_data);
                if (done) begin
                    done_cnt++;
                    done_at = out_q.size();
                end
            end
            held = out_valid && !out_ready;
            held_data = out_data;
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        out_ready = 1'b0;
        busy_after = busy;
        if (timed_out) begin
            checks++; errors++;
            $display("FAIL drain_timeout: outputs %0d required %0d", out_q.size(), npix);
            pulse_reset();
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat_flag: got %b expected 0", sat_flag); end
        reset = 1'b0;
    endtask

    task automatic test_single_pass();
        logic [W-1:0] v, got;
        in_vecs.delete();
        for (int i = 0; i < 4; i++) begin
            v = '0;
            for (int c = 0; c < COL; c++) v = put_ch(v, c, 10 * i + c);
            in_vecs.push_back(v);
        end
        build_model(4, 1, 1'b0);
        do_job(4, 1, 1'b0, 0, 1'b0, 1'b0);
        checks++; if (busy_start !== 1'b1) begin errors++; $display("FAIL single_busy_latency: got %b expected 1", busy_start); end
        checks++; if (first_lat != 3) begin errors++; $display("FAIL single_first_valid: got %0d expected 3", first_lat); end
        checks++; if (out_q.size() != 4) begin errors++; $display("FAIL single_count: got %0d expected 4", out_q.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < out_q.size()) ? out_q[i] : 'x;
            checks++; if (got !== in_vecs[i]) begin errors++; $display("FAIL single_out%0d: got %h expected %h", i, got, in_vecs[i]); end
        end
        checks++; if (done_at != 4 || done_cnt != 1) begin errors++; $display("FAIL single_done: got at %0d count %0d expected at 4 count 1", done_at, done_cnt); end
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL single_sat: got %b expected 0", sat_flag); end
        checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b expected 0", busy_after); end
    endtask

    task automatic test_forwarding();
        logic [W-1:0] v, want, got;
        in_vecs.delete();
        v = '0; want = '0;
        for (int c = 0; c < COL; c++) begin
            v = put_ch(v, c, 3);
            want = put_ch(want, c, 27);
        end
        for (int p = 0; p < 9; p++) in_vecs.push_back(v);
        do_job(1, 9, 1'b0, 0, 1'b0, 1'b0);
        got = (out_q.size() > 0) ? out_q[0] : 'x;
        checks++; if (got !== want) begin errors++; $display("FAIL fwd_sum: got %h expected %h", got, want); end
        checks++; if (done_at != 1) begin errors++; $display("FAIL fwd_done: got %0d expected 1", done_at); end
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL fwd_sat: got %b expected 0", sat_flag); end
    endtask

    task automatic test_sat_relu();
        logic [W-1:0] p0, p1, got;
        in_vecs.delete();
        for (int p = 0; p < 2; p++) begin
            p0 = put_ch(rand_vec(100), 0, 30000);
            p1 = put_ch(rand_vec(100), 1, -5);
            in_vecs.push_back(p0);
            in_vecs.push_back(p1);
        end
        build_model(2, 2, 1'b1);
        do_job(2, 2, 1'b1, 0, 1'b0, 1'b0);
        got = (out_q.size() > 0) ? out_q[0] : 'x;
        checks++; if (get_ch(got, 0) != 32767) begin errors++; $display("FAIL sat_clamp: got %0d expected 32767", get_ch(got, 0)); end
        checks++; if (got !== exp_q[0]) begin errors++; $display("FAIL sat_pix0: got %h expected %h", got, exp_q[0]); end
        got = (out_q.size() > 1) ? out_q[1] : 'x;
        checks++; if (get_ch(got, 1) != 0) begin errors++; $display("FAIL relu_neg: got %0d expected 0", get_ch(got, 1)); end
        checks++; if (got !== exp_q[1]) begin errors++; $display("FAIL relu_pix1: got %h expected %h", got, exp_q[1]); end
        checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag_set: got %b expected 1", sat_flag); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] got;
        in_vecs.delete();
        for (int k = 0; k < 24; k++) in_vecs.push_back(rand_vec(1000));
        build_model(8, 3, 1'b0);
        do_job(8, 3, 1'b0, 1, 1'b0, 1'b0);
        checks++; if (out_q.size() != 8) begin errors++; $display("FAIL bp_count: got %0d expected 8", out_q.size()); end
        for (int i = 0; i < 8; i++) begin
            got = (i < out_q.size()) ? out_q[i] : 'x;
            checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL bp_out%0d: got %h expected %h", i, got, exp_q[i]); end
        end
        checks++; if (stall_err != 0) begin errors++; $display("FAIL bp_stable: got %0d violations expected 0", stall_err); end
        checks++; if (done_at != 8 || done_cnt != 1) begin errors++; $display("FAIL bp_done: got at %0d count %0d expected at 8 count 1", done_at, done_cnt); end
    endtask

    task automatic test_illegal();
        int pix_cfg[3];
        int pass_cfg[3];
        logic [W-1:0] got;
        pix_cfg  = '{0, 65, 4};
        pass_cfg = '{2, 2, 0};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            num_pix = PW'(pix_cfg[k]); num_pass = PASS_W'(pass_cfg[k]); start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL illegal_cfg%0d: got busy %b expected 0", k, busy); end
        end
        in_vecs.delete();
        for (int k = 0; k < 10; k++) in_vecs.push_back(rand_vec(2000));
        build_model(5, 2, 1'b0);
        do_job(5, 2, 1'b0, 0, 1'b0, 1'b1);
        checks++; if (out_q.size() != 5) begin errors++; $display("FAIL ignore_start_count: got %0d expected 5", out_q.size()); end
        for (int i = 0; i < 5; i++) begin
            got = (i < out_q.size()) ? out_q[i] : 'x;
            checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL ignore_start_out%0d: got %h expected %h", i, got, exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        int cyc;
        logic [W-1:0] got;
        @(negedge clk);
        num_pix = PW'(4); num_pass = PASS_W'(2); relu_en = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc = 0; cyc = 0;
        while (acc < 5 && cyc < 50) begin
            in_valid = 1'b1;
            in_data = put_ch(rand_vec(100), 0, 32000);
            if (in_ready) acc++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 ||
                      sat_flag !== 1'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL mid_reset: got in_ready %b busy %b out_valid %b done %b sat %b data %h expected all 0",
                     in_ready, busy, out_valid, done, sat_flag, out_data);
        end
        @(negedge clk);
        reset = 1'b0;
        in_vecs.delete();
        for (int k = 0; k < 4; k++) in_vecs.push_back(rand_vec(5000));
        do_job(4, 1, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            got = (i < out_q.size()) ? out_q[i] : 'x;
            checks++; if (got !== in_vecs[i]) begin errors++; $display("FAIL post_reset_out%0d: got %h expected %h", i, got, in_vecs[i]); end
        end
    endtask

    task automatic test_random();
        int npix, npass, mag;
        bit relu;
        logic [W-1:0] got;
        for (int t = 0; t < 6; t++) begin
            npix  = $urandom_range(DEPTH, 1);
            npass = $urandom_range(4, 1);
            relu  = 1'($urandom_range(1));
            mag   = ($urandom_range(1) == 1) ? 20000 : 300;
            in_vecs.delete();
            for (int k = 0; k < npix * npass; k++) in_vecs.push_back(rand_vec(mag));
            build_model(npix, npass, relu);
            do_job(npix, npass, relu, 2, 1'b1, 1'b0);
            checks++; if (out_q.size() != npix || done_at != npix) begin errors++; $display("FAIL rand%0d_count: got %0d done at %0d expected %0d", t, out_q.size(), done_at, npix); end
            for (int i = 0; i < npix; i++) begin
                got = (i < out_q.size()) ? out_q[i] : 'x;
                checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL rand%0d_out%0d: got %h expected %h", t, i, got, exp_q[i]); end
            end
            checks++; if (sat_flag !== exp_sat) begin errors++; $display("FAIL rand%0d_sat: got %b expected %b", t, sat_flag, exp_sat); end
            checks++; if (stall_err != 0) begin errors++; $display("FAIL rand%0d_stable: got %0d violations expected 0", t, stall_err); end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; num_pix = '0; num_pass = '0; relu_en = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        test_reset();
        test_single_pass();
        test_forwarding();
        test_sat_relu();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
